// File: rtl/mux_pipe_pkg.sv
// Shared constants and helpers for the mux_pipe_n block.
package mux_pipe_pkg;

    localparam int MUX_PIPE_MAX_IN = 16;

    // Select width for an n-way mux, never narrower than one bit.
    function automatic int sel_w(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/mux_n_comb.sv
// Combinational WIDTH-bit N:1 mux with out-of-range select detection.
module mux_n_comb
    import mux_pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = sel_w(NUM_IN)
) (
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] data_in,
    output logic [WIDTH-1:0]        y,
    output logic                    range_err
);

    int unsigned sel_idx_s;

    // Select one input; an unused select code yields zero data and flags the error.
    always_comb begin
        sel_idx_s = 32'(sel);
        y         = '0;
        range_err = 1'b0;
        if (sel_idx_s < 32'(NUM_IN)) begin
            y         = data_in[sel_idx_s*WIDTH +: WIDTH];
            range_err = 1'b0;
        end else begin
            y         = '0;
            range_err = 1'b1;
        end
    end

endmodule

// File: rtl/mux_pipe_n.sv
// mux_pipe_n: registered N:1 mux with valid/ready handshake, flush and backpressure.
// Defining MUX_PIPE_SKID_EN adds a one-entry skid register and a registered in_ready.
module mux_pipe_n
    import mux_pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = sel_w(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] data_in,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    sel_err
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] sel;
        logic             err;
    } mux_beat_t;

    if (NUM_IN < 2 || NUM_IN > MUX_PIPE_MAX_IN) begin : g_bad_num_in
        $error("mux_pipe_n: NUM_IN out of range");
    end

    logic [WIDTH-1:0] mux_y_s;
    logic             mux_err_s;
    mux_beat_t        beat_s;
    mux_beat_t        out_r;
    logic             out_valid_r;
    logic             accept_s;

    mux_n_comb #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_mux (
        .sel       (sel),
        .data_in   (data_in),
        .y         (mux_y_s),
        .range_err (mux_err_s)
    );

    assign beat_s   = '{data: mux_y_s, sel: sel, err: mux_err_s};
    assign accept_s = in_valid && in_ready;

`ifdef MUX_PIPE_SKID_EN
    mux_beat_t skid_r;
    logic      skid_full_r;
    logic      out_free_s;

    assign out_free_s = !out_valid_r || out_ready;
    assign in_ready   = !skid_full_r && !reset;

    // Output plus skid stage: a beat arriving during a stall parks in the skid and drains first.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_r       <= '0;
            skid_full_r <= 1'b0;
            skid_r      <= '0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
            skid_full_r <= 1'b0;
        end else if (out_free_s) begin
            if (skid_full_r) begin
                out_valid_r <= 1'b1;
                out_r       <= skid_r;
                skid_full_r <= 1'b0;
            end else if (accept_s) begin
                out_valid_r <= 1'b1;
                out_r       <= beat_s;
            end else begin
                out_valid_r <= 1'b0;
            end
        end else if (accept_s) begin
            skid_r      <= beat_s;
            skid_full_r <= 1'b1;
        end
    end
`else
    assign in_ready = !reset && (!out_valid_r || out_ready);

    // Output stage: hold on stall, load on accept, drain when the beat leaves without a refill.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_r       <= '0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_r       <= beat_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end
`endif

    assign out_valid = out_valid_r;
    assign out_data  = out_r.data;
    assign out_sel   = out_r.sel;
    assign sel_err   = out_r.err;

endmodule
